feature_point_fifo: RTL

FEATURE_POINT_FIFO -- requirements
Module: feature_point_fifo

---
 rtl/feature_point_fifo.sv | 127 ++++++++++++
 1 files changed

// File: rtl/feature_point_fifo.sv
// feature_point_fifo
//   Buffers feature points from the extraction stage for the Hough voting
//   stage. Each entry is {eof, side, x, y}; a frame_start pulse inserts an
//   end-of-frame marker so the consumer can delimit frames. One slot is kept
//   back from points so a marker always fits after a burst of points.
//
// Ports
//   clk, rst                : clock, synchronous active-high reset
//   frame_start             : one-cycle pulse, enqueue marker, clear side counters
//   feature_de              : point valid; x_left != 0 selects left side
//   x/y_left, x/y_right     : point coordinates (inactive side is zero)
//   pt_valid/pt_ready       : first-word-fall-through head handshake
//   pt_x, pt_y, pt_side, pt_eof : head entry fields
//   fifo_count              : occupancy 0..DEPTH
//   left_cnt, right_cnt     : points accepted this frame per side (saturating)
//   drop_cnt                : points/markers lost since reset (saturating)
module feature_point_fifo #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_start,
    input  logic          feature_de,
    input  logic [11:0]   x_left,
    input  logic [11:0]   y_left,
    input  logic [11:0]   x_right,
    input  logic [11:0]   y_right,
    output logic          pt_valid,
    input  logic          pt_ready,
    output logic [11:0]   pt_x,
    output logic [11:0]   pt_y,
    output logic          pt_side,
    output logic          pt_eof,
    output logic [AW:0]   fifo_count,
    output logic [15:0]   left_cnt,
    output logic [15:0]   right_cnt,
    output logic [15:0]   drop_cnt
);

    typedef struct packed {
        logic        eof;
        logic        side;
        logic [11:0] x;
        logic [11:0] y;
    } entry_t;

    localparam logic [AW:0] CNT_FULL   = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_PT_MAX = (AW+1)'(DEPTH - 2);

    entry_t          mem [0:DEPTH-1];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    entry_t          wr_entry, head;
    logic            in_side;
    logic            push_mark, push_pt, push, pop;
    logic            mark_lost, pt_drop;
    logic [1:0]      drop_inc;

    function automatic logic [15:0] sat_add(input logic [15:0] v, input logic [1:0] inc);
        logic [16:0] sum;
        sum = {1'b0, v} + 17'(inc);
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    always_comb begin
        in_side   = (x_left == 12'd0);
        // Marker may take the last slot; points stop one short of full.
        push_mark = frame_start && (fifo_count != CNT_FULL);
        mark_lost = frame_start && (fifo_count == CNT_FULL);
        push_pt   = !frame_start && feature_de && (fifo_count <= CNT_PT_MAX);
        // Covers both a full FIFO and a point colliding with frame_start.
        pt_drop   = feature_de && !push_pt;
        drop_inc  = 2'(mark_lost) + 2'(pt_drop);
        push      = push_mark || push_pt;
        pop       = pt_valid && pt_ready;

        wr_entry  = '0;
        if (frame_start) begin
            wr_entry.eof = 1'b1;
        end else begin
            wr_entry.side = in_side;
            wr_entry.x    = in_side ? x_right : x_left;
            wr_entry.y    = in_side ? y_right : y_left;
        end
    end

    // Storage is not reset; head fields are only meaningful with pt_valid.
    always_ff @(posedge clk) begin
        if (!rst && push)
            mem[wr_ptr] <= wr_entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            left_cnt   <= '0;
            right_cnt  <= '0;
            drop_cnt   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
            drop_cnt <= sat_add(drop_cnt, drop_inc);
            if (frame_start) begin
                left_cnt  <= '0;
                right_cnt <= '0;
            end else if (push_pt) begin
                if (in_side) right_cnt <= sat_add(right_cnt, 2'd1);
                else         left_cnt  <= sat_add(left_cnt, 2'd1);
            end
        end
    end

    assign head     = mem[rd_ptr];
    assign pt_valid = (fifo_count != '0);
    assign pt_x     = head.x;
    assign pt_y     = head.y;
    assign pt_side  = head.side;
    assign pt_eof   = head.eof;

endmodule
